// File: rtl/regbank_arbiter.sv
// Arbiter sharing one synchronous-read register bank port between the FSMC bus slave and an internal requester.
// Define ARB_STATS_EN to build the saturating conflict counter behind stat_conflicts.
module regbank_arbiter #(
  parameter int ADRW   = 4,
  parameter int DATW   = 8,
  parameter int STARVE = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            bus_do_read,
  input  logic            bus_do_write,
  input  logic [ADRW-1:0] bus_adr,
  input  logic [DATW-1:0] bus_w_data,
  output logic [DATW-1:0] bus_r_data,
  output logic            bus_rvalid,
  input  logic            int_req,
  input  logic            int_we,
  input  logic [ADRW-1:0] int_adr,
  input  logic [DATW-1:0] int_wdata,
  output logic            int_gnt,
  output logic [DATW-1:0] int_rdata,
  output logic            int_rvalid,
  output logic            reg_en,
  output logic            reg_we,
  output logic [ADRW-1:0] reg_adr,
  output logic [DATW-1:0] reg_wdata,
  input  logic [DATW-1:0] reg_rdata,
  output logic [7:0]      stat_conflicts
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  logic            park_full;
  logic            park_we;
  logic [ADRW-1:0] park_adr;
  logic [DATW-1:0] park_wdata;
  logic [3:0]      wait_cnt;

  logic            fresh;
  logic            starved;
  logic            issue;
  logic            sel_int;
  logic            sel_we;
  logic [ADRW-1:0] sel_adr;
  logic [DATW-1:0] sel_wdata;
  logic            park_load;
  logic            grant;

  logic            p1_rd;
  logic            p1_int;
  logic            p2_rd;
  logic            p2_int;

  // Priority: parked strobe, starved internal, fresh strobe, internal.
  always_comb begin
    fresh     = bus_do_read | bus_do_write;
    starved   = (wait_cnt >= STARVE_LIM);
    issue     = 1'b0;
    sel_int   = 1'b0;
    sel_we    = 1'b0;
    sel_adr   = bus_adr;
    sel_wdata = bus_w_data;
    park_load = 1'b0;
    if (park_full) begin
      issue     = 1'b1;
      sel_we    = park_we;
      sel_adr   = park_adr;
      sel_wdata = park_wdata;
      park_load = fresh;
    end else if (int_req && starved) begin
      issue     = 1'b1;
      sel_int   = 1'b1;
      sel_we    = int_we;
      sel_adr   = int_adr;
      sel_wdata = int_wdata;
      park_load = fresh;
    end else if (fresh) begin
      issue     = 1'b1;
      sel_we    = bus_do_write;
    end else if (int_req) begin
      issue     = 1'b1;
      sel_int   = 1'b1;
      sel_we    = int_we;
      sel_adr   = int_adr;
      sel_wdata = int_wdata;
    end
    grant = issue & sel_int;
  end

  assign int_gnt = grant & nrst;

  // A parked entry always issues the cycle after capture, so it is full only while refilled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      park_full  <= 1'b0;
      park_we    <= 1'b0;
      park_adr   <= '0;
      park_wdata <= '0;
    end else begin
      park_full <= park_load;
      if (park_load) begin
        park_we    <= bus_do_write;
        park_adr   <= bus_adr;
        park_wdata <= bus_w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt <= '0;
    end else if (int_req && !grant) begin
      if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reg_en    <= 1'b0;
      reg_we    <= 1'b0;
      reg_adr   <= '0;
      reg_wdata <= '0;
      p1_rd     <= 1'b0;
      p1_int    <= 1'b0;
      p2_rd     <= 1'b0;
      p2_int    <= 1'b0;
    end else begin
      reg_en <= issue;
      reg_we <= issue & sel_we;
      if (issue) begin
        reg_adr   <= sel_adr;
        reg_wdata <= sel_wdata;
      end
      p1_rd  <= issue & ~sel_we;
      p1_int <= sel_int;
      p2_rd  <= p1_rd;
      p2_int <= p1_int;
    end
  end

  // Stage 2 lines up with reg_rdata being valid; route it to the tagged owner.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus_r_data <= '0;
      bus_rvalid <= 1'b0;
      int_rdata  <= '0;
      int_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= p2_rd & ~p2_int;
      int_rvalid <= p2_rd & p2_int;
      if (p2_rd && !p2_int) bus_r_data <= reg_rdata;
      if (p2_rd && p2_int)  int_rdata  <= reg_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic conflict;
  assign conflict = int_req & issue & ~sel_int;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_conflicts <= '0;
    end else if (conflict && stat_conflicts != 8'hFF) begin
      stat_conflicts <= stat_conflicts + 8'd1;
    end
  end
`else
  assign stat_conflicts = 8'd0;
`endif

endmodule

// File: tb/tb_regbank_arbiter.sv
// Randomized self-checking bench for regbank_arbiter against a transaction-level reference model.
module tb_regbank_arbiter;
  localparam int ADRW   = 4;
  localparam int DATW   = 8;
  localparam int STARVE = 2;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            bus_do_read = 1'b0;
  logic            bus_do_write = 1'b0;
  logic [ADRW-1:0] bus_adr = '0;
  logic [DATW-1:0] bus_w_data = '0;
  logic [DATW-1:0] bus_r_data;
  logic            bus_rvalid;
  logic            int_req = 1'b0;
  logic            int_we = 1'b0;
  logic [ADRW-1:0] int_adr = '0;
  logic [DATW-1:0] int_wdata = '0;
  logic            int_gnt;
  logic [DATW-1:0] int_rdata;
  logic            int_rvalid;
  logic            reg_en;
  logic            reg_we;
  logic [ADRW-1:0] reg_adr;
  logic [DATW-1:0] reg_wdata;
  logic [DATW-1:0] reg_rdata = '0;
  logic [7:0]      stat_conflicts;

  always #5 clk = ~clk;

  regbank_arbiter #(.ADRW(ADRW), .DATW(DATW), .STARVE(STARVE)) dut (
    .clk(clk), .nrst(nrst),
    .bus_do_read(bus_do_read), .bus_do_write(bus_do_write),
    .bus_adr(bus_adr), .bus_w_data(bus_w_data),
    .bus_r_data(bus_r_data), .bus_rvalid(bus_rvalid),
    .int_req(int_req), .int_we(int_we), .int_adr(int_adr), .int_wdata(int_wdata),
    .int_gnt(int_gnt), .int_rdata(int_rdata), .int_rvalid(int_rvalid),
    .reg_en(reg_en), .reg_we(reg_we), .reg_adr(reg_adr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .stat_conflicts(stat_conflicts)
  );

  // Synchronous-read register bank.
  logic [DATW-1:0] bank [2**ADRW];
  always @(posedge clk) begin
    if (reg_en) begin
      if (reg_we) bank[reg_adr] <= reg_wdata;
      else        reg_rdata     <= bank[reg_adr];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int obs_bus_rv = 0;
  int gnt_cyc = -1;

  // Reference model: memory image, park entry, wait count and a cycle-indexed expectation ring.
  logic [DATW-1:0] model_mem [2**ADRW];
  logic            s_en [8];
  logic            s_we [8];
  logic [ADRW-1:0] s_adr [8];
  logic [DATW-1:0] s_wd [8];
  logic            r_bus [8];
  logic            r_int [8];
  logic [DATW-1:0] r_data [8];
  logic            pk_full = 1'b0;
  logic            pk_we = 1'b0;
  logic [ADRW-1:0] pk_adr = '0;
  logic [DATW-1:0] pk_wd = '0;
  int              m_wait = 0;
  int              m_conf = 0;
  logic            m_gnt = 1'b0;
  logic [ADRW-1:0] m_adr = '0;
  logic [DATW-1:0] m_bus_data = '0;
  logic [DATW-1:0] m_int_data = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) begin
      s_en[i] = 1'b0; s_we[i] = 1'b0; s_adr[i] = '0; s_wd[i] = '0;
      r_bus[i] = 1'b0; r_int[i] = 1'b0; r_data[i] = '0;
    end
    pk_full = 1'b0; m_wait = 0; m_conf = 0; m_gnt = 1'b0;
    m_adr = '0; m_bus_data = '0; m_int_data = '0;
  endtask

  task automatic modelStep();
    int s;
    int s1;
    int s3;
    int exp_stat;
    logic fresh;
    logic issue;
    logic from_int;
    logic we;
    logic [ADRW-1:0] adr;
    logic [DATW-1:0] wd;
    s = cyc % 8;
    if (s_en[s]) m_adr = s_adr[s];
    checkOutput("reg_en", reg_en, s_en[s]);
    checkOutput("reg_we", reg_we, s_en[s] & s_we[s]);
    checkOutput("reg_adr", reg_adr, m_adr);
    if (s_en[s] && s_we[s]) checkOutput("reg_wdata", reg_wdata, s_wd[s]);
    if (r_bus[s]) m_bus_data = r_data[s];
    if (r_int[s]) m_int_data = r_data[s];
    checkOutput("bus_rvalid", bus_rvalid, r_bus[s]);
    checkOutput("bus_r_data", bus_r_data, m_bus_data);
    checkOutput("int_rvalid", int_rvalid, r_int[s]);
    checkOutput("int_rdata", int_rdata, m_int_data);
`ifdef ARB_STATS_EN
    exp_stat = (m_conf > 255) ? 255 : m_conf;
`else
    exp_stat = 0;
`endif
    checkOutput("stat_conflicts", stat_conflicts, exp_stat);
    s_en[s] = 1'b0; r_bus[s] = 1'b0; r_int[s] = 1'b0;

    fresh = bus_do_read | bus_do_write;
    issue = 1'b0; from_int = 1'b0; we = 1'b0; adr = '0; wd = '0;
    if (pk_full) begin
      issue = 1'b1; we = pk_we; adr = pk_adr; wd = pk_wd;
      pk_full = fresh;
      if (fresh) begin pk_we = bus_do_write; pk_adr = bus_adr; pk_wd = bus_w_data; end
    end else if (int_req && m_wait >= STARVE) begin
      issue = 1'b1; from_int = 1'b1; we = int_we; adr = int_adr; wd = int_wdata;
      pk_full = fresh;
      if (fresh) begin pk_we = bus_do_write; pk_adr = bus_adr; pk_wd = bus_w_data; end
    end else if (fresh) begin
      issue = 1'b1; we = bus_do_write; adr = bus_adr; wd = bus_w_data;
    end else if (int_req) begin
      issue = 1'b1; from_int = 1'b1; we = int_we; adr = int_adr; wd = int_wdata;
    end
    m_gnt = issue & from_int;
    checkOutput("int_gnt", int_gnt, m_gnt);
    if (int_req && issue && !from_int) m_conf++;
    if (int_req && !m_gnt) m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
    else                   m_wait = 0;
    if (issue) begin
      s1 = (cyc + 1) % 8;
      s_en[s1] = 1'b1; s_we[s1] = we; s_adr[s1] = adr; s_wd[s1] = wd;
      if (we) begin
        model_mem[adr] = wd;
      end else begin
        s3 = (cyc + 3) % 8;
        r_bus[s3] = ~from_int; r_int[s3] = from_int; r_data[s3] = model_mem[adr];
      end
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [ADRW-1:0] adr,
                               input logic [DATW-1:0] wd, input logic start_int, input logic iwe,
                               input logic [ADRW-1:0] iadr, input logic [DATW-1:0] iwd);
    bus_do_read = rd; bus_do_write = wr; bus_adr = adr; bus_w_data = wd;
    if (!int_req && start_int) begin
      int_req = 1'b1; int_we = iwe; int_adr = iadr; int_wdata = iwd;
    end
    @(negedge clk);
    if (bus_rvalid) obs_bus_rv++;
    if (int_gnt) gnt_cyc = cyc;
    modelStep();
    cyc++;
    @(posedge clk);
    #1;
    bus_do_read = 1'b0; bus_do_write = 1'b0;
    if (m_gnt) int_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic resetPulse();
    nrst = 1'b0;
    bus_do_read = 1'b0; bus_do_write = 1'b0; int_req = 1'b0;
    clearModel();
    @(negedge clk);
    checkOutput("rst_bus_r_data", bus_r_data, 0);
    checkOutput("rst_bus_rvalid", bus_rvalid, 0);
    checkOutput("rst_int_gnt", int_gnt, 0);
    checkOutput("rst_int_rdata", int_rdata, 0);
    checkOutput("rst_int_rvalid", int_rvalid, 0);
    checkOutput("rst_reg_en", reg_en, 0);
    checkOutput("rst_reg_we", reg_we, 0);
    checkOutput("rst_reg_adr", reg_adr, 0);
    checkOutput("rst_reg_wdata", reg_wdata, 0);
    checkOutput("rst_stat", stat_conflicts, 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    cyc++;
  endtask

  int base;
  int rv0;
  int exp_sat;

  initial begin
    for (int i = 0; i < 2**ADRW; i++) model_mem[i] = '0;
    resetPulse();

    // Fill every register back-to-back so later reads have known contents.
    for (int a = 0; a < 2**ADRW; a++)
      applyStimulus(1'b0, 1'b1, ADRW'(a), DATW'($urandom), 1'b0, 1'b0, '0, '0);
    idle(2);

    // Bus write then read of the same register.
    applyStimulus(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, '0, '0);
    idle(1);
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, '0);
    idle(2);
    checkOutput("t1_bus_rvalid", bus_rvalid, 1);
    checkOutput("t1_bus_r_data", bus_r_data, 8'hA5);
    checkOutput("t1_int_rvalid", int_rvalid, 0);
    idle(3);

    // Internal write colliding with a bus read.
    base = cyc;
    applyStimulus(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 4'd1, 8'h3C);
    idle(1);
`ifdef ARB_STATS_EN
    checkOutput("t2_stat", stat_conflicts, 1);
`else
    checkOutput("t2_stat", stat_conflicts, 0);
`endif
    checkOutput("t2_gnt_delay", gnt_cyc - base, 1);
    idle(4);

    // Held internal read against six back-to-back bus reads.
    base = cyc;
    rv0 = obs_bus_rv;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, ADRW'($urandom), 8'h00, i == 0, 1'b0, 4'd7, 8'h00);
    idle(6);
    checkOutput("t3_gnt_cycle", gnt_cyc - base, 2);
    checkOutput("t3_bus_rv_count", obs_bus_rv - rv0, 6);

    // Simultaneous read and write strobes act as a write only.
    rv0 = obs_bus_rv;
    applyStimulus(1'b1, 1'b1, 4'd5, 8'h11, 1'b0, 1'b0, '0, '0);
    idle(5);
    checkOutput("t4_bus_rv_count", obs_bus_rv - rv0, 0);

    // Reset one cycle after a read strobe drops the read.
    rv0 = obs_bus_rv;
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, '0);
    resetPulse();
    idle(5);
    checkOutput("t5_bus_rv_count", obs_bus_rv - rv0, 0);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(3) == 0, $urandom_range(3) == 0, ADRW'($urandom), DATW'($urandom),
                    $urandom_range(2) == 0, $urandom_range(1) == 1, ADRW'($urandom), DATW'($urandom));
    idle(6);

    // Continuous bus reads with a permanently requesting internal source.
    for (int i = 0; i < 310; i++)
      applyStimulus(1'b1, 1'b0, ADRW'($urandom), 8'h00, 1'b1, $urandom_range(1) == 1,
                    ADRW'($urandom), DATW'($urandom));
`ifdef ARB_STATS_EN
    exp_sat = 255;
`else
    exp_sat = 0;
`endif
    checkOutput("t6_stat_sat", stat_conflicts, exp_sat);
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Shares one synchronous-read register bank port between the FSMC bus slave (single-cycle `do_read`/`do_write` strobes on `clk`) and one internal fabric requester using a req/gnt handshake. Sits between the bus slave and the register bank, alongside the LED/pulse-count logic that will become the internal requester. Bus accesses normally win. A starvation guard bounds internal wait, and a one-entry park buffer ensures no bus strobe is ever lost.

## Interface
- `ADRW`, default 4: register address width.
- `DATW`, default 8: register data width.
- `STARVE`, default 4: number of consecutive deferred cycles after which the internal requester gets priority (range 1..15).
- `clk` in 1: system clock (PLL output).
- `nrst` in 1: reset, asynchronous, active-low.
- `bus_do_read` in 1: one-cycle read strobe from the bus slave.
- `bus_do_write` in 1: one-cycle write strobe from the bus slave.
- `bus_adr` in ADRW: bus address, valid with its strobe.
- `bus_w_data` in DATW: bus write data, valid with `bus_do_write`.
- `bus_r_data` out DATW: registered read result for the bus.
- `bus_rvalid` out 1: one-cycle pulse when `bus_r_data` is updated.
- `int_req` in 1: internal request; held high until `int_gnt`.
- `int_we` in 1: internal request is a write.
- `int_adr` in ADRW: internal address; stable while `int_req` is high.
- `int_wdata` in DATW: internal write data; stable while `int_req` is high.
- `int_gnt` out 1: one-cycle pulse in the cycle the internal access is issued.
- `int_rdata` out DATW: registered read result for the internal requester.
- `int_rvalid` out 1: one-cycle pulse when `int_rdata` is updated.
- `reg_en` out 1: bank access enable.
- `reg_we` out 1: bank write enable.
- `reg_adr` out ADRW: bank address.
- `reg_wdata` out DATW: bank write data.
- `reg_rdata` in DATW: bank read data; valid in the cycle after `reg_en` with `reg_we` low.
- `stat_conflicts` out 8: conflict counter (see Configuration).

## Operation
- Each cycle, the arbiter selects at most one source, in this priority order:
  1. The park buffer, if full.
  2. The internal requester, if its starvation flag is set.
  3. A fresh bus strobe.
  4. The internal requester.
- Source ties:
  - `bus_do_read` and `bus_do_write` high together are treated as a write; the read is discarded.
  - A fresh bus strobe that loses arbitration is captured into the park buffer (address, data, rd/wr). The buffer issues in the next cycle.
  - If the buffer is issuing and a fresh strobe arrives in the same cycle, the fresh strobe is parked again. The buffer frees and refills in one cycle.
- Starvation: `wait_cnt` (4-bit) increments each cycle `int_req` is high without `int_gnt`. It clears on `int_gnt` or when `int_req` is low. The starvation flag is `wait_cnt >= STARVE`.
- `int_gnt` is combinational in the selection cycle and is never asserted unless `int_req` is high.
- Each issued access carries an owner tag (bus/int) and a read flag through a two-stage pipeline. Read data returns only to the owner. Writes produce no rvalid.
- Conflict: a cycle with `int_req` high, no grant, and a bus access (fresh or parked) selected.

## Timing
- Selection happens in cycle k. At edge k+1 the `reg_*` outputs are registered, with `reg_en` high for one cycle. The bank presents `reg_rdata` during cycle k+2. At edge k+3 the data is registered into `bus_r_data`/`int_rdata` with the matching rvalid high for one cycle.
- Read latency from strobe to `bus_rvalid`:
  - 3 cycles when the strobe is selected directly.
  - 4 cycles when it is parked.
- Back-to-back accesses issue one per cycle with no bubbles.
- Data outputs hold their last value when the matching rvalid is low.
- `reg_wdata`/`reg_adr` hold their last value when `reg_en` is low.
- Reset values: all outputs, the park buffer, `wait_cnt`, the pipeline and `stat_conflicts` are 0.
- `nrst` asserted mid-operation drops all in-flight and parked accesses. No rvalid is issued for them after release.

## Configuration
- `ARB_STATS_EN` defined: `stat_conflicts` is an 8-bit counter that increments on each conflict cycle, saturates at 255, and clears only on reset.
- `ARB_STATS_EN` undefined: `stat_conflicts` is tied to 0 and no counter logic is built. The port is present either way.

## Test plan
- Bus write `adr=3, data=0xA5`, then bus read `adr=3` 2 cycles later: `reg_we` pulses with `adr=3`, `wdata=0xA5`. `bus_rvalid` pulses 3 cycles after the read strobe with `bus_r_data=0xA5`. `int_rvalid` stays 0.
- `int_req` write `adr=1, 0x3C` in the same cycle as bus read `adr=2`: bus issued first. `int_gnt` comes 1 cycle later. `stat_conflicts=1` with `ARB_STATS_EN`, 0 without.
- `STARVE=2`, `int_req` read held while bus strobes arrive every cycle for 6 cycles: `int_gnt` occurs on the 3rd cycle. That cycle's bus strobe is parked and issued the next cycle. Every strobe gets exactly one `bus_rvalid`, in order.
- Simultaneous `bus_do_read` and `bus_do_write` at `adr=5, 0x11`: one write issued with `reg_we=1`. No `bus_rvalid`.
- `nrst` pulsed low one cycle after a bus read strobe: no `bus_rvalid` after release. All outputs are 0 during reset.
- 300 conflict cycles with `ARB_STATS_EN` defined: `stat_conflicts` saturates at 255.
